sec_hash_arbiter: RTL and testbench
===================================

// Module: sec_hash_arbiter
// PURPOSE
//  Multi-channel successor to the single-requester SHA-256 path in the minimum security module.
//  Arbitrates NUM_CH requester channels (boot control, bus translation, IP cores) onto one
//  sha_top-style engine (block/init/next/ready/digest_valid).
//  Adds round-robin fairness, a per-channel PUF-authorisation gate (from the PCM S_c result),
//  multi-block message locking and a hang watchdog.
// PARAMETERS
//  NUM_CH      4     requester channels, 2..16
//  BLOCK_W     512   message block width
//  DIGEST_W    256   digest width
//  TIMEOUT_CYC 1024  max cycles in WAIT or LOCK before abort, >=16
//  ERRCNT_W    8     saturating error counter width
// PORTS
//  clk             in   1                 single clock; all logic on posedge
//  rst             in   1                 synchronous, active-high reset
//  ch_req          in   NUM_CH            per-channel request, level, held until grant
//  ch_first        in   NUM_CH            1=first block of message (engine init), 0=continuation (next)
//  ch_last         in   NUM_CH            1=final block; releases channel lock on completion
//  ch_block        in   NUM_CH*BLOCK_W    per-channel block, channel i at [i*BLOCK_W +: BLOCK_W]
//  ch_auth         in   NUM_CH            channel authorised (latched PCM S_c per IP)
//  ch_grant        out  NUM_CH            one-hot 1-cycle pulse: block accepted
//  ch_done         out  NUM_CH            one-hot 1-cycle pulse: digest valid on ch_digest
//  ch_err          out  NUM_CH            one-hot 1-cycle pulse: rejected or aborted
//  ch_digest       out  DIGEST_W          registered digest; holds until next done
//  eng_block       out  BLOCK_W           registered block to engine
//  eng_init        out  1                 1-cycle start pulse, new message
//  eng_next        out  1                 1-cycle start pulse, continuation block
//  eng_ready       in   1                 engine idle
//  eng_digest      in   DIGEST_W          engine digest
//  eng_digest_valid in  1                 engine digest valid
//  busy            out  1                 state != IDLE
//  owner           out  $clog2(NUM_CH)    current or last owner index
//  err_cnt         out  ERRCNT_W          saturating count of ch_err pulses
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NUM_CH-1, all outputs 0, ch_digest=0, err_cnt=0, timer=0.
//  States: IDLE, ISSUE, WAIT, DONE, LOCK, ERR.
//  IDLE:  if eng_ready and |ch_req, winner w = first requester searching from rr_ptr+1 with wrap.
//         ch_auth[w]=0 -> ERR. ch_auth[w]=1 and ch_first[w]=0 -> ERR (continuation with no open message).
//         Otherwise latch ch_block[w] into eng_block and go to ISSUE.
//  ISSUE (1 cycle): eng_init=ch_first_q, eng_next=~ch_first_q, ch_grant[w]=1, timer cleared.
//  WAIT:  advance once eng_digest_valid&eng_ready, sampled no earlier than the 2nd cycle after ISSUE
//         (masks stale valid).
//         Capture eng_digest into ch_digest -> DONE. timer==TIMEOUT_CYC-1 -> ERR.
//  DONE (1 cycle): ch_done[w]=1.
//         last_q=1 -> IDLE and rr_ptr=w.
//         last_q=0 -> LOCK, timer cleared.
//  LOCK:  only channel w is serviced; other requests wait.
//         ch_req[w] with ch_first[w]=0 and ch_auth[w]=1 -> latch block, ISSUE.
//         ch_req[w] with ch_first[w]=1 or ch_auth[w]=0 -> ERR (protocol or auth loss mid-message).
//         timer expiry -> ERR.
//  ERR (1 cycle): ch_err[w]=1, err_cnt+1 saturating, rr_ptr=w, -> IDLE. Lock is dropped.
//  Latency: IDLE->grant 2 cycles; done 1 cycle after the qualifying digest_valid.
//  Simultaneous events:
//    - ch_req drop between selection and ISSUE is ignored: the block is already latched.
//    - Auth deassert during WAIT does not abort the in-flight block; it is caught at the next LOCK check.
//  Reset mid-operation returns all state to reset values next edge. Engine is not reset by this block.
//  ch_grant, ch_done and ch_err are mutually exclusive and at most one bit hot.
// STRUCTURE
//  Package sec_hash_pkg: typedef enum logic[2:0] arb_state_t; localparams for the default widths.
//  Sub-module rr_pick #(N): combinational round-robin picker (req, ptr -> idx, valid).
//  Reused for future camellia arbiter.
// TESTING
//  1. Reset, then ch_req=4'b0001 first=last=1 auth=1, engine model 20 cycles
//     -> grant[0] at cycle 2, done[0] with model digest, eng_init=1 exactly once.
//  2. ch_req=4'b1111 all single-block, auth=1 -> service order 0,1,2,3 then 0; no done overlaps.
//  3. ch_req[2] auth=0 -> err[2] pulse, err_cnt=1, eng_init/eng_next never asserted.
//  4. Ch1 3-block message, ch3 requesting throughout
//     -> ch1 served init,next,next uninterrupted; ch3 granted only after ch1 last done.
//  5. Engine never returns valid -> err[w] at TIMEOUT_CYC cycles after ISSUE, state back to IDLE.
//  6. rst asserted in WAIT -> next cycle busy=0, outputs 0; fresh request completes normally.
//     Also check err_cnt saturates at 2^ERRCNT_W-1.

Source files
------------

// File: rtl/sec_hash_pkg.sv
// Shared types and default sizes for the multi-channel hash arbiter.
package sec_hash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_LOCK  = 3'd4,
    ST_ERR   = 3'd5
  } arb_state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_BLOCK_W     = 512;
  localparam int DEF_DIGEST_W    = 256;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_ERRCNT_W    = 8;

endpackage

// File: rtl/sec_hash_arbiter_if.sv
// Requester channels, engine handshake and status of the hash arbiter.
// slave = arbiter view, master = requesters/engine/observer view.
interface sec_hash_arbiter_if
  import sec_hash_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int BLOCK_W  = DEF_BLOCK_W,
  parameter int DIGEST_W = DEF_DIGEST_W,
  parameter int ERRCNT_W = DEF_ERRCNT_W
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]         ch_req;
  logic [NUM_CH-1:0]         ch_first;
  logic [NUM_CH-1:0]         ch_last;
  logic [NUM_CH*BLOCK_W-1:0] ch_block;
  logic [NUM_CH-1:0]         ch_auth;
  logic [NUM_CH-1:0]         ch_grant;
  logic [NUM_CH-1:0]         ch_done;
  logic [NUM_CH-1:0]         ch_err;
  logic [DIGEST_W-1:0]       ch_digest;
  logic [BLOCK_W-1:0]        eng_block;
  logic                      eng_init;
  logic                      eng_next;
  logic                      eng_ready;
  logic [DIGEST_W-1:0]       eng_digest;
  logic                      eng_digest_valid;
  logic                      busy;
  logic [IDX_W-1:0]          owner;
  logic [ERRCNT_W-1:0]       err_cnt;

  modport slave (
    input  ch_req, ch_first, ch_last, ch_block, ch_auth,
    input  eng_ready, eng_digest, eng_digest_valid,
    output ch_grant, ch_done, ch_err, ch_digest,
    output eng_block, eng_init, eng_next,
    output busy, owner, err_cnt
  );

  modport master (
    output ch_req, ch_first, ch_last, ch_block, ch_auth,
    output eng_ready, eng_digest, eng_digest_valid,
    input  ch_grant, ch_done, ch_err, ch_digest,
    input  eng_block, eng_init, eng_next,
    input  busy, owner, err_cnt
  );

endinterface

// File: rtl/sec_hash_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan ptr+1 .. ptr+N so the last-served channel has lowest priority.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!valid && req[(int'(ptr) + k) % N]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/sec_hash_arbiter.sv
// Multi-channel arbiter in front of a single block hash engine: round-robin
// fairness, per-channel authorisation gate, multi-block message locking and
// a hang watchdog on the engine and on a locked requester.
module sec_hash_arbiter
  import sec_hash_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int BLOCK_W     = DEF_BLOCK_W,
  parameter int DIGEST_W    = DEF_DIGEST_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int ERRCNT_W    = DEF_ERRCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  sec_hash_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_CH - 1);

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    owner_q, rr_ptr_q, pick_idx, sel_idx;
  logic                pick_vld;
  logic                first_q, last_q;
  logic [TMR_W-1:0]    timer_q;
  logic [BLOCK_W-1:0]  eng_block_q, sel_blk;
  logic [DIGEST_W-1:0] ch_digest_q;
  logic [ERRCNT_W-1:0] err_cnt_q;
  logic                idle_go, idle_ok, lock_go, lock_ok, dig_ok, tmo, blk_take;
  logic [NUM_CH-1:0]   grant_c, done_c, err_c;
  logic                init_c, next_c;

  rr_pick #(.N(NUM_CH), .IW(IDX_W)) u_pick (
    .req   (bus.ch_req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  // While locked only the owner's inputs are looked at.
  assign sel_idx  = (state_q == ST_LOCK) ? owner_q : pick_idx;
  assign sel_blk  = bus.ch_block[int'(sel_idx)*BLOCK_W +: BLOCK_W];
  assign idle_go  = (state_q == ST_IDLE) && bus.eng_ready && pick_vld;
  assign idle_ok  = bus.ch_auth[pick_idx] && bus.ch_first[pick_idx];
  assign lock_go  = (state_q == ST_LOCK) && bus.ch_req[owner_q];
  assign lock_ok  = !bus.ch_first[owner_q] && bus.ch_auth[owner_q];
  // timer is 0 on the first WAIT cycle, so a valid left over from a
  // previous block cannot complete the new one.
  assign dig_ok   = bus.eng_digest_valid && bus.eng_ready && (timer_q != '0);
  assign tmo      = (timer_q == TMR_LAST);
  assign blk_take = (idle_go && idle_ok) || (lock_go && lock_ok);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (idle_go) state_d = idle_ok ? ST_ISSUE : ST_ERR;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (dig_ok)   state_d = ST_DONE;
        else if (tmo) state_d = ST_ERR;
      end
      ST_DONE:  state_d = last_q ? ST_IDLE : ST_LOCK;
      ST_LOCK: begin
        if (lock_go)  state_d = lock_ok ? ST_ISSUE : ST_ERR;
        else if (tmo) state_d = ST_ERR;
      end
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Owner, message flags, watchdog, fairness pointer, digest and error count.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      timer_q     <= '0;
      rr_ptr_q    <= PTR_RST;
      eng_block_q <= '0;
      ch_digest_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (idle_go) owner_q <= pick_idx;
      if (blk_take) begin
        eng_block_q <= sel_blk;
        first_q     <= bus.ch_first[sel_idx];
        last_q      <= bus.ch_last[sel_idx];
      end
      timer_q <= (state_q == ST_WAIT || state_q == ST_LOCK) ? timer_q + 1'b1 : '0;
      if (state_q == ST_WAIT && dig_ok) ch_digest_q <= bus.eng_digest;
      if ((state_q == ST_DONE && last_q) || state_q == ST_ERR) rr_ptr_q <= owner_q;
      if (state_q == ST_ERR) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  // Pulse outputs decoded from the state; at most one is hot per cycle.
  always_comb begin
    grant_c = '0;
    done_c  = '0;
    err_c   = '0;
    init_c  = 1'b0;
    next_c  = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        grant_c[owner_q] = 1'b1;
        init_c           = first_q;
        next_c           = !first_q;
      end
      ST_DONE:  done_c[owner_q] = 1'b1;
      ST_ERR:   err_c[owner_q]  = 1'b1;
      default:  ;
    endcase
  end

  assign bus.ch_grant  = grant_c;
  assign bus.ch_done   = done_c;
  assign bus.ch_err    = err_c;
  assign bus.eng_init  = init_c;
  assign bus.eng_next  = next_c;
  assign bus.ch_digest = ch_digest_q;
  assign bus.eng_block = eng_block_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.owner     = owner_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sec_hash_arbiter.sv
// Scoreboard bench for sec_hash_arbiter with a small behavioural hash engine.
module tb_sec_hash_arbiter;

  localparam int NUM_CH      = 4;
  localparam int BLOCK_W     = 64;
  localparam int DIGEST_W    = 64;
  localparam int TIMEOUT_CYC = 32;
  localparam int ERRCNT_W    = 3;
  localparam int ENG_LAT     = 20;
  localparam int K_GRANT = 0, K_DONE = 1, K_ERR = 2;

  typedef struct {
    int                  kind;
    int                  ch;
    logic [DIGEST_W-1:0] dig;
  } evt_t;

  logic clk, rst, eng_rst, eng_hang;
  evt_t sb[$];
  int   n_vec = 0, n_err = 0, cyc = 0;
  int   n_init = 0, n_next = 0;
  int   last_grant_cyc = -1, last_err_cyc = -1;
  logic prev_valid = 1'b0;
  int   nblk[NUM_CH], blk_sent[NUM_CH], rearm[NUM_CH], msg[NUM_CH];

  sec_hash_arbiter_if #(.NUM_CH(NUM_CH), .BLOCK_W(BLOCK_W), .DIGEST_W(DIGEST_W),
                        .ERRCNT_W(ERRCNT_W)) bus ();

  sec_hash_arbiter #(.NUM_CH(NUM_CH), .BLOCK_W(BLOCK_W), .DIGEST_W(DIGEST_W),
                     .TIMEOUT_CYC(TIMEOUT_CYC), .ERRCNT_W(ERRCNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BLOCK_W-1:0] mk_block(input int c, input int m, input int k);
    return {16'(c), 16'(m), 16'(k), 16'hC0DE};
  endfunction

  function automatic logic [DIGEST_W-1:0] h_init(input logic [BLOCK_W-1:0] b);
    return b ^ 64'h6A09_E667_F3BC_C908;
  endfunction

  function automatic logic [DIGEST_W-1:0] h_next(input logic [DIGEST_W-1:0] s,
                                                 input logic [BLOCK_W-1:0] b);
    return {s[55:0], s[63:56]} ^ b ^ 64'hBB67_AE85_84CA_A73B;
  endfunction

  // Engine: one block at a time, digest after ENG_LAT cycles; hang mode ignores starts.
  logic [DIGEST_W-1:0] eng_state;
  logic                eng_busy;
  int                  eng_cnt;
  always @(posedge clk) begin
    if (eng_rst) begin
      eng_busy             <= 1'b0;
      eng_cnt              <= 0;
      eng_state            <= '0;
      bus.eng_ready        <= 1'b1;
      bus.eng_digest_valid <= 1'b0;
      bus.eng_digest       <= '0;
    end else begin
      bus.eng_digest_valid <= 1'b0;
      if (eng_busy) begin
        if (eng_cnt == 0) begin
          eng_busy             <= 1'b0;
          bus.eng_ready        <= 1'b1;
          bus.eng_digest_valid <= 1'b1;
          bus.eng_digest       <= eng_state;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end else if ((bus.eng_init || bus.eng_next) && !eng_hang) begin
        eng_state     <= bus.eng_init ? h_init(bus.eng_block) : h_next(eng_state, bus.eng_block);
        eng_busy      <= 1'b1;
        bus.eng_ready <= 1'b0;
        eng_cnt       <= ENG_LAT - 2;
      end
    end
  end

  task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_msg(input int c, input int m, input int n);
    logic [DIGEST_W-1:0] s;
    evt_t x;
    s = '0;
    for (int k = 0; k < n; k++) begin
      s = (k == 0) ? h_init(mk_block(c, m, k)) : h_next(s, mk_block(c, m, k));
      x.kind = K_GRANT; x.ch = c; x.dig = '0; sb.push_back(x);
      x.kind = K_DONE;  x.ch = c; x.dig = s;  sb.push_back(x);
    end
  endtask

  task automatic expect_err(input int c);
    evt_t x;
    x.kind = K_ERR; x.ch = c; x.dig = '0;
    sb.push_back(x);
  endtask

  task automatic arm(input int c, input int n, input logic auth);
    msg[c]++;
    nblk[c]     = n;
    blk_sent[c] = 0;
    bus.ch_first[c] = 1'b1;
    bus.ch_last[c]  = (n == 1);
    bus.ch_auth[c]  = auth;
    bus.ch_block[c*BLOCK_W +: BLOCK_W] = mk_block(c, msg[c], 0);
    bus.ch_req[c] = 1'b1;
  endtask

  // One clock: sample outputs #1 after the edge, score them, then react as the requesters.
  task automatic step();
    logic [NUM_CH-1:0] g, d, e, v;
    int   ch, kind;
    evt_t x;
    @(posedge clk);
    #1;
    cyc++;
    g = bus.ch_grant; d = bus.ch_done; e = bus.ch_err;
    if (bus.eng_init) n_init++;
    if (bus.eng_next) n_next++;
    v = g | d | e;
    if (v != '0) begin
      ch = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) if (v[i]) ch = i;
      kind = (g != '0) ? K_GRANT : ((d != '0) ? K_DONE : K_ERR);
      check_vec("one_hot", 64'($countones({g, d, e})), 64'd1);
      if (kind == K_GRANT) last_grant_cyc = cyc;
      if (kind == K_ERR)   last_err_cyc   = cyc;
      if (sb.size() == 0) begin
        check_vec("sb_unexpected", 64'(v), 64'd0);
      end else begin
        x = sb.pop_front();
        check_vec("evt_kind", 64'(kind), 64'(x.kind));
        check_vec("evt_ch", 64'(ch), 64'(x.ch));
        if (kind == K_DONE) begin
          check_vec("digest", 64'(bus.ch_digest), 64'(x.dig));
          check_vec("done_lat", 64'(prev_valid), 64'd1);
        end
      end
    end
    prev_valid = bus.eng_digest_valid;
    for (int c = 0; c < NUM_CH; c++) begin
      if (g[c]) begin
        blk_sent[c]++;
        if (blk_sent[c] < nblk[c]) begin
          bus.ch_first[c] = 1'b0;
          bus.ch_last[c]  = (blk_sent[c] == nblk[c] - 1);
          bus.ch_block[c*BLOCK_W +: BLOCK_W] = mk_block(c, msg[c], blk_sent[c]);
        end else if (rearm[c] > 0) begin
          rearm[c]--;
          msg[c]++;
          blk_sent[c]     = 0;
          bus.ch_first[c] = 1'b1;
          bus.ch_last[c]  = (nblk[c] == 1);
          bus.ch_block[c*BLOCK_W +: BLOCK_W] = mk_block(c, msg[c], 0);
        end else begin
          bus.ch_req[c] = 1'b0;
        end
      end
      if (e[c]) bus.ch_req[c] = 1'b0;
    end
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((bus.ch_req != '0 || bus.busy || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check_vec("idle_busy", 64'(bus.busy), 64'd0);
    check_vec("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_grant(input string tag, input int budget);
    int g0 = last_grant_cyc;
    int n  = 0;
    while (last_grant_cyc == g0 && n < budget) begin
      step();
      n++;
    end
    check_vec(tag, 64'(last_grant_cyc != g0), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_vec({tag, "_busy"},  64'(bus.busy), 64'd0);
    check_vec({tag, "_pulse"}, 64'({bus.ch_grant, bus.ch_done, bus.ch_err,
                                    bus.eng_init, bus.eng_next}), 64'd0);
    check_vec({tag, "_dig"},   64'(bus.ch_digest), 64'd0);
    check_vec({tag, "_blk"},   64'(bus.eng_block), 64'd0);
    check_vec({tag, "_owner"}, 64'(bus.owner), 64'd0);
    check_vec({tag, "_ecnt"},  64'(bus.err_cnt), 64'd0);
  endtask

  initial begin
    int a0, i0, x0;
    rst = 1'b1; eng_rst = 1'b1; eng_hang = 1'b0;
    bus.ch_req = '0; bus.ch_first = '0; bus.ch_last = '0;
    bus.ch_auth = '0; bus.ch_block = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      nblk[c] = 0; blk_sent[c] = 0; rearm[c] = 0; msg[c] = 0;
    end
    step(); step();
    eng_rst = 1'b0;
    step();
    rst = 1'b0;
    check_quiet("reset");

    // 1: single-block message on channel 0.
    arm(0, 1, 1'b1);
    expect_msg(0, msg[0], 1);
    a0 = cyc;
    step();
    check_vec("t1_grant_lat", 64'(last_grant_cyc), 64'(a0 + 1));
    run_idle(100);
    check_vec("t1_init", 64'(n_init), 64'd1);
    check_vec("t1_next", 64'(n_next), 64'd0);

    // 2: all four request from a fresh pointer; channel 0 asks twice.
    do_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      arm(c, 1, 1'b1);
      expect_msg(c, msg[c], 1);
    end
    rearm[0] = 1;
    expect_msg(0, msg[0] + 1, 1);
    run_idle(300);
    check_vec("t2_init", 64'(n_init), 64'd6);

    // 3: unauthorised requester, then a continuation with no open message.
    i0 = n_init; x0 = n_next;
    arm(2, 1, 1'b0);
    expect_err(2);
    run_idle(20);
    check_vec("t3_ecnt", 64'(bus.err_cnt), 64'd1);
    arm(0, 1, 1'b1);
    bus.ch_first[0] = 1'b0;
    expect_err(0);
    run_idle(20);
    check_vec("t3b_ecnt", 64'(bus.err_cnt), 64'd2);
    check_vec("t3_starts", 64'(n_init + n_next), 64'(i0 + x0));

    // 4: three-block message on ch1 must not be interrupted by ch3.
    i0 = n_init; x0 = n_next;
    arm(1, 3, 1'b1);
    expect_msg(1, msg[1], 3);
    expect_msg(3, msg[3] + 1, 1);
    wait_grant("t4_first_grant", 10);
    arm(3, 1, 1'b1);
    run_idle(400);
    check_vec("t4_init", 64'(n_init - i0), 64'd2);
    check_vec("t4_next", 64'(n_next - x0), 64'd2);

    // 5: engine never answers; watchdog aborts the block.
    eng_hang = 1'b1;
    arm(0, 1, 1'b1);
    sb.push_back('{kind: K_GRANT, ch: 0, dig: '0});
    expect_err(0);
    run_idle(TIMEOUT_CYC + 20);
    check_vec("t5_tmo_lat", 64'(last_err_cyc - last_grant_cyc), 64'(TIMEOUT_CYC + 1));
    check_vec("t5_ecnt", 64'(bus.err_cnt), 64'd3);
    eng_hang = 1'b0;

    // 6: reset while waiting on the engine, then a fresh request.
    arm(0, 1, 1'b1);
    sb.push_back('{kind: K_GRANT, ch: 0, dig: '0});
    wait_grant("t6_grant", 10);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_quiet("t6_rst");
    arm(1, 1, 1'b1);
    expect_msg(1, msg[1], 1);
    run_idle(200);

    // Error counter saturates at 2^ERRCNT_W-1.
    for (int i = 0; i < 9; i++) begin
      arm(2, 1, 1'b0);
      expect_err(2);
      run_idle(20);
      check_vec("sat_ecnt", 64'(bus.err_cnt), 64'((i + 1 < 7) ? i + 1 : 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
